// File: rtl/avst_tx_pkt_arbiter.sv
// Packet-granular Avalon-ST arbiter: N sources share one 64-bit MAC TX bus, whole packets, IPG idle cycles between.
// Optional build macro ARB_STRICT_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module avst_tx_pkt_arbiter #(
  parameter int N   = 2,
  parameter int IPG = 4
) (
  input  logic            clk_out,
  input  logic            reset,
  input  logic [64*N-1:0] in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    in_sop,
  input  logic [N-1:0]    in_eop,
  input  logic [3*N-1:0]  in_empty,
  input  logic [6*N-1:0]  in_error,
  output logic [63:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_sop,
  output logic            out_eop,
  output logic [2:0]      out_empty,
  output logic [5:0]      out_error,
  output logic [1:0]      grant,
  output logic            busy,
  output logic            proto_err
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic [7:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic        r_proto_err, w_proto_err_nxt;
`ifndef ARB_STRICT_PRIO_EN
  logic [1:0]  r_last, w_last_nxt;
  logic        w_found;
`endif

  logic [N-1:0] w_req;
  logic [1:0]   w_pick;
  logic         w_g_valid, w_g_sop, w_g_eop;
  logic [63:0]  w_g_data;
  logic [2:0]   w_g_empty;
  logic [5:0]   w_g_error;

  always_comb begin
    w_g_valid = 1'b0;
    w_g_sop   = 1'b0;
    w_g_eop   = 1'b0;
    w_g_data  = '0;
    w_g_empty = '0;
    w_g_error = '0;
    for (int k = 0; k < N; k++) begin
      if (r_grant == 2'(k)) begin
        w_g_valid = in_valid[k];
        w_g_sop   = in_sop[k];
        w_g_eop   = in_eop[k];
        w_g_data  = in_data[64*k +: 64];
        w_g_empty = in_empty[3*k +: 3];
        w_g_error = in_error[6*k +: 6];
      end
    end
  end

  // Arbitration: a port requests with the first beat of a packet.
  always_comb begin
    w_req  = in_valid & in_sop;
    w_pick = '0;
`ifdef ARB_STRICT_PRIO_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req[k]) w_pick = 2'(k);
    end
`else
    w_found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int k = 0; k < N; k++) begin
        if (!w_found && w_req[k] && (((int'(r_last) + off) % N) == k)) begin
          w_pick  = 2'(k);
          w_found = 1'b1;
        end
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_proto_err_nxt = r_proto_err;
`ifndef ARB_STRICT_PRIO_EN
    w_last_nxt      = r_last;
`endif
    in_ready  = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = w_g_data;
    out_empty = w_g_empty;
    out_error = w_g_error;
    case (r_state)
      IDLE: begin
        // Stray mid-packet beats are drained so a broken source cannot wedge the bus.
        in_ready = in_valid & ~in_sop;
        if (|(in_valid & ~in_sop)) w_proto_err_nxt = 1'b1;
        if (|w_req) begin
          w_state_nxt = XFER;
          w_grant_nxt = w_pick;
`ifndef ARB_STRICT_PRIO_EN
          w_last_nxt  = w_pick;
`endif
        end
      end
      XFER: begin
        out_valid = w_g_valid;
        out_sop   = w_g_sop;
        out_eop   = w_g_eop;
        for (int k = 0; k < N; k++) begin
          if (r_grant == 2'(k)) in_ready[k] = out_ready;
        end
        if (w_g_valid && out_ready && w_g_eop) begin
          if (IPG > 0) begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = 8'(IPG);
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        if (r_gap_cnt <= 8'd1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_out) begin
    if (reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_gap_cnt   <= '0;
      r_proto_err <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
      r_last      <= 2'(N - 1);
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_proto_err <= w_proto_err_nxt;
`ifndef ARB_STRICT_PRIO_EN
      r_last      <= w_last_nxt;
`endif
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == XFER);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_avst_tx_pkt_arbiter.sv
// Directed bench for avst_tx_pkt_arbiter: instance a (IPG=4) for the table and corner sequences, instance b (IPG=0) for round-robin.
module tb_avst_tx_pkt_arbiter;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [127:0] a_data;  logic [1:0] a_valid, a_ready, a_sop, a_eop;
  logic [5:0]   a_empty; logic [11:0] a_error;
  logic [63:0]  a_odata; logic a_ovalid, a_oready, a_osop, a_oeop;
  logic [2:0]   a_oempty; logic [5:0] a_oerror; logic [1:0] a_grant; logic a_busy, a_perr;

  logic [127:0] b_data;  logic [1:0] b_valid, b_ready, b_sop, b_eop;
  logic [5:0]   b_empty; logic [11:0] b_error;
  logic [63:0]  b_odata; logic b_ovalid, b_oready, b_osop, b_oeop;
  logic [2:0]   b_oempty; logic [5:0] b_oerror; logic [1:0] b_grant; logic b_busy, b_perr;

  avst_tx_pkt_arbiter #(.N(2), .IPG(4)) dut_a (
    .clk_out(clk), .reset(rst),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready), .in_sop(a_sop), .in_eop(a_eop),
    .in_empty(a_empty), .in_error(a_error),
    .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .out_sop(a_osop), .out_eop(a_oeop),
    .out_empty(a_oempty), .out_error(a_oerror), .grant(a_grant), .busy(a_busy), .proto_err(a_perr));

  avst_tx_pkt_arbiter #(.N(2), .IPG(0)) dut_b (
    .clk_out(clk), .reset(rst),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready), .in_sop(b_sop), .in_eop(b_eop),
    .in_empty(b_empty), .in_error(b_error),
    .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready), .out_sop(b_osop), .out_eop(b_oeop),
    .out_empty(b_oempty), .out_error(b_oerror), .grant(b_grant), .busy(b_busy), .proto_err(b_perr));

  typedef struct {
    logic [1:0]  valid, sop, eop;
    logic [2:0]  empty0;
    logic [63:0] data0;
    logic        oready;
    logic        e_ovalid, e_osop, e_oeop;
    logic [2:0]  e_oempty;
    logic [63:0] e_odata;
    logic [1:0]  e_ready;
    logic        e_busy;
    logic [1:0]  e_grant;
    logic        e_perr;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] v, s, e, input logic [2:0] emp, input logic [63:0] d,
                              input logic ord, eov, esop, eeop, input logic [2:0] eemp,
                              input logic [63:0] ed, input logic [1:0] erdy, input logic eb,
                              input logic [1:0] eg, input logic ep);
    vec_t r;
    r.valid = v; r.sop = s; r.eop = e; r.empty0 = emp; r.data0 = d; r.oready = ord;
    r.e_ovalid = eov; r.e_osop = esop; r.e_oeop = eeop; r.e_oempty = eemp; r.e_odata = ed;
    r.e_ready = erdy; r.e_busy = eb; r.e_grant = eg; r.e_perr = ep;
    return r;
  endfunction

  function automatic logic [63:0] rrd(input int p, input int k, input int b);
    return (64'(p) << 32) | (64'(k) << 8) | 64'(b);
  endfunction

  task automatic idle_inputs();
    a_valid = '0; a_sop = '0; a_eop = '0; a_empty = '0; a_error = '0; a_data = '0; a_oready = 1'b1;
    b_valid = '0; b_sop = '0; b_eop = '0; b_empty = '0; b_error = '0; b_data = '0; b_oready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[17];

  initial begin
    int j, rcv, npkt, idle, cur_g;
    int pk[2];
    int bt[2];
    int exp_g[4];
    logic [63:0] bp_base;

    rst = 1'b1;
    idle_inputs();

    // Single-port packet, IPG, single-beat packet, then protocol error drain.
    vt[0]  = mk(2'b01, 2'b01, 2'b00, 3'd0, 64'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0,  2'b00, 1'b0, 2'd0, 1'b0);
    vt[1]  = mk(2'b01, 2'b01, 2'b00, 3'd0, 64'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA1, 2'b01, 1'b1, 2'd0, 1'b0);
    vt[2]  = mk(2'b01, 2'b00, 2'b00, 3'd0, 64'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'hA2, 2'b01, 1'b1, 2'd0, 1'b0);
    vt[3]  = mk(2'b01, 2'b00, 2'b01, 3'd2, 64'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 64'hA3, 2'b01, 1'b1, 2'd0, 1'b0);
    for (int i = 4; i <= 8; i++)
      vt[i] = mk(2'b01, 2'b01, 2'b01, 3'd0, 64'hB1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'b00, 1'b0, 2'd0, 1'b0);
    vt[9]  = mk(2'b01, 2'b01, 2'b01, 3'd0, 64'hB1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 64'hB1, 2'b01, 1'b1, 2'd0, 1'b0);
    for (int i = 10; i <= 13; i++)
      vt[i] = mk(2'b10, 2'b00, 2'b00, 3'd0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0, 2'b00, 1'b0, 2'd0, 1'b0);
    vt[14] = mk(2'b10, 2'b00, 2'b00, 3'd0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0,  2'b10, 1'b0, 2'd0, 1'b0);
    vt[15] = mk(2'b00, 2'b00, 2'b00, 3'd0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0,  2'b00, 1'b0, 2'd0, 1'b1);
    vt[16] = mk(2'b00, 2'b00, 2'b00, 3'd0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0,  2'b00, 1'b0, 2'd0, 1'b1);

    do_reset();
    #1;
    chk("rst.grant_a", 64'(a_grant), 64'd0);
    chk("rst.busy_a", 64'(a_busy), 64'd0);
    chk("rst.perr_a", 64'(a_perr), 64'd0);
    chk("rst.ovalid_a", 64'(a_ovalid), 64'd0);
    chk("rst.busy_b", 64'(b_busy), 64'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_valid = vt[i].valid; a_sop = vt[i].sop; a_eop = vt[i].eop;
      a_empty = {3'd0, vt[i].empty0}; a_data = {D1, vt[i].data0}; a_oready = vt[i].oready;
      #1;
      chk($sformatf("v%0d.out_valid", i), 64'(a_ovalid), 64'(vt[i].e_ovalid));
      if (vt[i].e_ovalid) begin
        chk($sformatf("v%0d.out_sop", i), 64'(a_osop), 64'(vt[i].e_osop));
        chk($sformatf("v%0d.out_eop", i), 64'(a_oeop), 64'(vt[i].e_oeop));
        chk($sformatf("v%0d.out_empty", i), 64'(a_oempty), 64'(vt[i].e_oempty));
        chk($sformatf("v%0d.out_data", i), a_odata, vt[i].e_odata);
      end else begin
        chk($sformatf("v%0d.out_sop", i), 64'(a_osop), 64'd0);
        chk($sformatf("v%0d.out_eop", i), 64'(a_oeop), 64'd0);
      end
      chk($sformatf("v%0d.in_ready", i), 64'(a_ready), 64'(vt[i].e_ready));
      chk($sformatf("v%0d.busy", i), 64'(a_busy), 64'(vt[i].e_busy));
      chk($sformatf("v%0d.grant", i), 64'(a_grant), 64'(vt[i].e_grant));
      chk($sformatf("v%0d.proto_err", i), 64'(a_perr), 64'(vt[i].e_perr));
    end

    // Backpressure: 4-beat packet on port 0 while port 1 waits with a request.
    do_reset();
    bp_base = 64'hB0B0_0000_0000_0000;
    j = 0; rcv = 0;
    for (int cyc = 0; cyc < 30 && j < 4; cyc++) begin
      @(negedge clk);
      a_valid = {1'b1, 1'b1}; a_sop = {1'b1, (j == 0)}; a_eop = {1'b0, (j == 3)};
      a_data = {D1, bp_base + 64'(j)};
      case ((cyc + 3) % 4)
        0, 3: a_oready = 1'b1;
        default: a_oready = 1'b0;
      endcase
      #1;
      if (a_busy) chk($sformatf("bp%0d.in_ready0", cyc), 64'(a_ready[0]), 64'(a_oready));
      chk($sformatf("bp%0d.in_ready1", cyc), 64'(a_ready[1]), 64'd0);
      if (a_ovalid && a_oready) begin
        chk($sformatf("bp.beat%0d", rcv), a_odata, bp_base + 64'(rcv));
        rcv++;
      end
      if (a_valid[0] && a_ready[0]) j++;
    end
    chk("bp.beats_sent", 64'(j), 64'd4);
    chk("bp.beats_recv", 64'(rcv), 64'd4);
    @(negedge clk);
    a_valid = 2'b00; a_sop = 2'b00; a_eop = 2'b00;
    #1;
    chk("bp.after_ovalid", 64'(a_ovalid), 64'd0);

    // Round-robin on the IPG=0 instance, both ports always offering 2-beat packets.
`ifdef ARB_STRICT_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    do_reset();
    pk = '{0, 0}; bt = '{0, 0};
    npkt = 0; idle = 0; cur_g = 0;
    for (int cyc = 0; cyc < 40 && npkt < 4; cyc++) begin
      @(negedge clk);
      b_oready = 1'b1;
      b_valid = 2'b11;
      for (int p = 0; p < 2; p++) begin
        b_sop[p] = (bt[p] == 0);
        b_eop[p] = (bt[p] == 1);
        b_data[64*p +: 64] = rrd(p, pk[p], bt[p]);
      end
      #1;
      if (!b_ovalid) idle++;
      if (b_ovalid && b_oready) begin
        if (b_osop) begin
          cur_g = exp_g[npkt];
          chk($sformatf("rr.pkt%0d.grant", npkt), 64'(b_grant), 64'(cur_g));
          chk($sformatf("rr.pkt%0d.idle", npkt), 64'(idle), 64'd1);
        end
        chk($sformatf("rr.pkt%0d.data", npkt), b_odata, rrd(cur_g, pk[cur_g], bt[cur_g]));
        if (b_oeop) begin
          npkt++;
          idle = 0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (b_valid[p] && b_ready[p]) begin
          if (bt[p] == 1) begin
            bt[p] = 0;
            pk[p]++;
          end else begin
            bt[p] = 1;
          end
        end
      end
    end
    chk("rr.packets", 64'(npkt), 64'd4);

    // Reset mid-packet: 2 of 5 beats on port 1, then reset, then a fresh port-1 request.
    do_reset();
    @(negedge clk);
    a_valid = 2'b01; a_sop = 2'b00; a_eop = 2'b00; a_data = '0;
    #1;
    chk("mr.drain_ready", 64'(a_ready), 64'b01);
    @(negedge clk);
    a_valid = 2'b10; a_sop = 2'b10; a_data = {64'hC0, 64'h0};
    #1;
    chk("mr.perr_set", 64'(a_perr), 64'd1);
    chk("mr.no_ovalid", 64'(a_ovalid), 64'd0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      a_sop = {(b == 0), 1'b0};
      a_data = {64'hC0 + 64'(b), 64'h0};
      #1;
      chk($sformatf("mr.beat%0d.valid", b), 64'(a_ovalid), 64'd1);
      chk($sformatf("mr.beat%0d.grant", b), 64'(a_grant), 64'd1);
      chk($sformatf("mr.beat%0d.data", b), a_odata, 64'hC0 + 64'(b));
    end
    @(negedge clk);
    rst = 1'b1;
    a_sop = 2'b00; a_data = {64'hC2, 64'h0};
    @(negedge clk);
    rst = 1'b0;
    a_valid = 2'b10; a_sop = 2'b10; a_eop = 2'b00; a_data = {64'hF1, 64'h0};
    #1;
    chk("mr.post.ovalid", 64'(a_ovalid), 64'd0);
    chk("mr.post.busy", 64'(a_busy), 64'd0);
    chk("mr.post.grant", 64'(a_grant), 64'd0);
    chk("mr.post.perr", 64'(a_perr), 64'd0);
    chk("mr.post.ready", 64'(a_ready), 64'b00);
    @(negedge clk);
    #1;
    chk("mr.fresh.ovalid", 64'(a_ovalid), 64'd1);
    chk("mr.fresh.osop", 64'(a_osop), 64'd1);
    chk("mr.fresh.grant", 64'(a_grant), 64'd1);
    chk("mr.fresh.data", a_odata, 64'hF1);
    chk("mr.fresh.busy", 64'(a_busy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
